// File: rtl/div_unit_pkg.sv
// Shared state encodings and handshake constants for the multi-cycle divider.
package div_unit_pkg;

  typedef enum logic [1:0] {
    DIV_FREE   = 2'b00,
    DIV_BYZERO = 2'b01,
    DIV_ON     = 2'b10,
    DIV_END    = 2'b11
  } div_state_e;

  localparam logic DIV_RESULT_READY     = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;
  localparam logic DIV_START            = 1'b1;
  localparam logic DIV_STOP             = 1'b0;

endpackage

// File: rtl/div_unit.sv
// Restoring divider for DIV/DIVU: one quotient bit per cycle, result is {remainder, quotient}.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 signed_div_i,
  input  logic [WIDTH-1:0]     opdata1_i,
  input  logic [WIDTH-1:0]     opdata2_i,
  input  logic                 start_i,
  input  logic                 annul_i,
  output logic [2*WIDTH-1:0]   result_o,
  output logic                 ready_o
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  div_state_e           r_state, w_state_nxt;
  logic [CNT_W-1:0]     r_cnt, w_cnt_nxt;
  logic [WIDTH-1:0]     r_rem, w_rem_nxt;
  logic [WIDTH-1:0]     r_quo, w_quo_nxt;
  logic [WIDTH-1:0]     r_div, w_div_nxt;
  logic                 r_neg_q, w_neg_q_nxt;
  logic                 r_neg_r, w_neg_r_nxt;
  logic [2*WIDTH-1:0]   r_result, w_result_nxt;
  logic                 r_ready, w_ready_nxt;

  logic [WIDTH-1:0]     w_abs1, w_abs2;
  logic [WIDTH:0]       w_partial;
  logic                 w_ge;
  logic [WIDTH-1:0]     w_diff;
  logic [WIDTH-1:0]     w_q_fix, w_r_fix;

  assign w_abs1 = (signed_div_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
  assign w_abs2 = (signed_div_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;

  // The shifted partial remainder can exceed WIDTH bits for large divisors, so compare at WIDTH+1.
  assign w_partial = {r_rem, r_quo[WIDTH-1]};
  assign w_ge      = w_partial >= {1'b0, r_div};
  assign w_diff    = WIDTH'(w_partial - {1'b0, r_div});

  assign w_q_fix = r_neg_q ? -r_quo : r_quo;
  assign w_r_fix = r_neg_r ? -r_rem : r_rem;

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_rem_nxt    = r_rem;
    w_quo_nxt    = r_quo;
    w_div_nxt    = r_div;
    w_neg_q_nxt  = r_neg_q;
    w_neg_r_nxt  = r_neg_r;
    w_result_nxt = r_result;
    w_ready_nxt  = r_ready;
    case (r_state)
      DIV_FREE: begin
        if (start_i == DIV_START && !annul_i) begin
          w_state_nxt = (opdata2_i == '0) ? DIV_BYZERO : DIV_ON;
          w_cnt_nxt   = '0;
          w_rem_nxt   = '0;
          w_quo_nxt   = w_abs1;
          w_div_nxt   = w_abs2;
          w_neg_q_nxt = signed_div_i & (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
          w_neg_r_nxt = signed_div_i & opdata1_i[WIDTH-1];
        end
      end
      DIV_BYZERO: begin
        w_state_nxt  = annul_i ? DIV_FREE : DIV_END;
        w_result_nxt = '0;
        w_ready_nxt  = DIV_RESULT_NOT_READY;
      end
      DIV_ON: begin
        if (annul_i) begin
          w_state_nxt  = DIV_FREE;
          w_result_nxt = '0;
          w_ready_nxt  = DIV_RESULT_NOT_READY;
        end else if (r_cnt != CNT_W'(WIDTH)) begin
          w_rem_nxt = w_ge ? w_diff : w_partial[WIDTH-1:0];
          w_quo_nxt = {r_quo[WIDTH-2:0], w_ge};
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end else begin
          w_result_nxt = {w_r_fix, w_q_fix};
          w_ready_nxt  = DIV_RESULT_READY;
          w_state_nxt  = DIV_END;
        end
      end
      DIV_END: begin
        if (start_i == DIV_STOP) begin
          w_state_nxt  = DIV_FREE;
          w_ready_nxt  = DIV_RESULT_NOT_READY;
          w_result_nxt = '0;
        end else begin
          w_ready_nxt  = DIV_RESULT_READY;
        end
      end
      default: w_state_nxt = DIV_FREE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= DIV_FREE;
      r_cnt    <= '0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_div    <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_result <= '0;
      r_ready  <= DIV_RESULT_NOT_READY;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_rem    <= w_rem_nxt;
      r_quo    <= w_quo_nxt;
      r_div    <= w_div_nxt;
      r_neg_q  <= w_neg_q_nxt;
      r_neg_r  <= w_neg_r_nxt;
      r_result <= w_result_nxt;
      r_ready  <= w_ready_nxt;
    end
  end

  assign result_o = r_result;
  assign ready_o  = r_ready;

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: 32-bit instance for the main cases, 8-bit instance for the narrow build.
module tb_div_unit;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, signed_div, start, annul;
  logic [31:0] op1, op2;
  logic [63:0] result;
  logic        ready;

  logic        signed_div8, start8, annul8;
  logic [7:0]  op1_8, op2_8;
  logic [15:0] result8;
  logic        ready8;

  logic [63:0] exp_q[$];
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  div_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .signed_div_i(signed_div), .opdata1_i(op1), .opdata2_i(op2),
    .start_i(start), .annul_i(annul), .result_o(result), .ready_o(ready)
  );

  div_unit #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .signed_div_i(signed_div8), .opdata1_i(op1_8), .opdata2_i(op2_8),
    .start_i(start8), .annul_i(annul8), .result_o(result8), .ready_o(ready8)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
    end
  endtask

  // Reference via 64-bit arithmetic: truncating division, remainder follows dividend sign.
  function automatic logic [63:0] model(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'd0) return 64'd0;
    if (!sgn) return {a % b, a / b};
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    q  = sa / sb;
    r  = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input string tag, input logic sgn, input logic [31:0] a,
                        input logic [31:0] b, input int exp_lat);
    logic [63:0] exp_v;
    int lat;
    signed_div = sgn; op1 = a; op2 = b; start = 1'b1;
    exp_q.push_back(model(sgn, a, b));
    tick();
    op1 = $urandom; op2 = 32'd0; signed_div = ~sgn;
    lat = 0;
    while (!ready && lat < 60) begin
      tick();
      lat++;
    end
    check_eq({tag, " latency"}, 64'(lat), 64'(exp_lat));
    exp_v = exp_q.pop_front();
    check_eq({tag, " result"}, result, exp_v);
    annul = 1'b1;
    tick();
    annul = 1'b0;
    check_eq({tag, " hold ready"}, 64'(ready), 64'd1);
    check_eq({tag, " hold result"}, result, exp_v);
    start = 1'b0;
    tick();
    check_eq({tag, " drop ready"}, 64'(ready), 64'd0);
    check_eq({tag, " drop result"}, result, 64'd0);
  endtask

  initial begin
    int lat8;
    logic [63:0] exp8;
    logic [31:0] ra, rb;
    logic rs;

    rst = 1'b1; start = 1'b0; annul = 1'b0; signed_div = 1'b0; op1 = '0; op2 = '0;
    start8 = 1'b0; annul8 = 1'b0; signed_div8 = 1'b0; op1_8 = '0; op2_8 = '0;
    tick(); tick();
    check_eq("reset result", result, 64'd0);
    check_eq("reset ready", 64'(ready), 64'd0);
    rst = 1'b0;
    tick();

    run_op("u100/7", 1'b0, 32'd100, 32'd7, 33);
    run_op("s-7/2", 1'b1, 32'hFFFF_FFF9, 32'd2, 33);
    run_op("s7/-2", 1'b1, 32'd7, 32'hFFFF_FFFE, 33);
    run_op("div0", 1'b0, 32'd5, 32'd0, 2);

    // Annul mid-operation, then restart on the following cycle.
    signed_div = 1'b0; op1 = 32'd1000; op2 = 32'd3; start = 1'b1;
    tick();
    repeat (10) tick();
    check_eq("annul busy ready", 64'(ready), 64'd0);
    annul = 1'b1;
    tick();
    annul = 1'b0;
    check_eq("annul ready", 64'(ready), 64'd0);
    check_eq("annul result", result, 64'd0);
    run_op("uFFFFFFFF/16", 1'b0, 32'hFFFF_FFFF, 32'h10, 33);

    // Annul while FREE must block acceptance even with start high.
    signed_div = 1'b0; op1 = 32'd77; op2 = 32'd5; start = 1'b1; annul = 1'b1;
    tick();
    annul = 1'b0;
    run_op("annul-free", 1'b0, 32'd77, 32'd5, 33);

    // Synchronous reset in the middle of an operation.
    signed_div = 1'b0; op1 = 32'd12345; op2 = 32'd11; start = 1'b1;
    tick();
    repeat (5) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("rst-on result", result, 64'd0);
    check_eq("rst-on ready", 64'(ready), 64'd0);
    run_op("s-min/-1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 33);

    repeat (6) begin
      rs = 1'($urandom_range(0, 1));
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 20)) : $urandom;
      if ($urandom_range(0, 7) == 0) rb = 32'd0;
      run_op(rs ? "rand-s" : "rand-u", rs, ra, rb, (rb == 32'd0) ? 2 : 33);
    end

    // Narrow build: 200/3 unsigned.
    signed_div8 = 1'b0; op1_8 = 8'd200; op2_8 = 8'd3; start8 = 1'b1;
    exp_q.push_back({48'd0, 8'(8'd200 % 8'd3), 8'(8'd200 / 8'd3)});
    tick();
    op1_8 = 8'hFF; op2_8 = 8'h01;
    lat8 = 0;
    while (!ready8 && lat8 < 30) begin
      tick();
      lat8++;
    end
    check_eq("w8 latency", 64'(lat8), 64'd9);
    exp8 = exp_q.pop_front();
    check_eq("w8 result", 64'(result8), exp8);
    repeat (3) tick();
    check_eq("w8 hold ready", 64'(ready8), 64'd1);
    check_eq("w8 hold result", 64'(result8), exp8);
    start8 = 1'b0;
    tick();
    check_eq("w8 drop ready", 64'(ready8), 64'd0);
    check_eq("w8 drop result", 64'(result8), 64'd0);

    check_eq("scoreboard empty", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
